// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word width and the
// mode-0 clock polarity/phase used by both ends of the link.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        TRAIL
    } state_t;

    localparam int SPI_DATA_W = 8;

    localparam bit CPOL = 1'b0;
    localparam bit CPHA = 1'b0;

endpackage : spi_pkg

// File: rtl/spi_master_if.sv
// Local-controller handshake plus SPI pins of the master, bundled so the
// engine and its user see one port each.
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);

    logic              start;
    logic [DATA_W-1:0] data_tx;
    logic [DATA_W-1:0] data_rx;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, data_tx, miso,
        output sclk, ss, mosi, data_rx, busy, done
    );

    modport slave (
        output start, data_tx, miso,
        input  sclk, ss, mosi, data_rx, busy, done
    );

endinterface : spi_master_if

// File: rtl/spi_clk_div.sv
// Half-period timer for sclk: emits a one-cycle tick every CLK_DIV cycles,
// restarting from zero whenever clear is high.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule : spi_clk_div

// File: rtl/spi_master.sv
// SPI mode-0 master: one start-triggered transfer of DATA_W bits, MSB first,
// with busy/done status back to the local controller.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    state_t             state_q,   state_d;
    logic [DATA_W-1:0]  tx_q,      tx_d;
    logic [DATA_W-1:0]  rx_q,      rx_d;
    logic [DATA_W-1:0]  data_rx_q, data_rx_d;
    logic [BIT_W-1:0]   bit_q,     bit_d;
    logic               sclk_q,    sclk_d;
    logic               ss_q,      ss_d;
    logic               mosi_q,    mosi_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               tick;
    logic               div_clear;

    // The half-period timer restarts on every state entry and idles at zero.
    assign div_clear = (state_q == IDLE) || (state_d != state_q);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .tick  (tick)
    );

    always_comb begin
        // NOTE: every target gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_rx_d = data_rx_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        ss_d      = ss_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d    = bus.data_tx;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = bus.data_tx[DATA_W-1];
                    bit_d   = BIT_W'(DATA_W);
                    state_d = XFER;
                end
            end

            XFER: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[DATA_W-2:0], bus.miso};
                        bit_d  = bit_q - BIT_W'(1);
                    end else begin
                        sclk_d = 1'b0;
                        // The last falling edge leaves mosi on the final bit.
                        if (bit_q == '0) begin
                            state_d = TRAIL;
                        end else begin
                            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                            mosi_d = tx_q[DATA_W-2];
                        end
                    end
                end
            end

            TRAIL: begin
                if (tick) begin
                    ss_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    data_rx_d = rx_q;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
            bit_q     <= '0;
            sclk_q    <= CPOL;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_rx_q <= data_rx_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.ss      = ss_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.data_rx = data_rx_q;

endmodule : spi_master

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a table of single transfers on a CLK_DIV=2
// instance (loopback or mode-0 slave model) plus reset-abort and CLK_DIV=1 streaming.
module tb_spi_master;

    logic clk  = 1'b0;
    logic rst2 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(8)) bus2 ();
    spi_master_if #(.DATA_W(8)) bus1 ();

    spi_master #(.DATA_W(8), .CLK_DIV(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));
    spi_master #(.DATA_W(8), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural mode-0 slave, evaluated half a cycle away from the DUT edge.
    logic       use_loop    = 1'b1;
    logic [7:0] slave_word  = 8'h00;
    logic       model_miso  = 1'b0;
    logic [7:0] s_tx        = 8'h00;
    logic [7:0] s_rx        = 8'h00;
    logic       prev_ss_m   = 1'b1;
    logic       prev_sclk_m = 1'b0;

    assign bus2.miso = use_loop ? bus2.mosi : model_miso;
    assign bus1.miso = bus1.mosi;

    always @(negedge clk) begin
        if (prev_ss_m && !bus2.ss) begin
            s_tx       = slave_word;
            model_miso = slave_word[7];
            s_rx       = 8'h00;
        end else if (!bus2.ss) begin
            if (bus2.sclk && !prev_sclk_m) s_rx = {s_rx[6:0], bus2.mosi};
            if (!bus2.sclk && prev_sclk_m) begin
                s_tx       = {s_tx[6:0], 1'b0};
                model_miso = s_tx[7];
            end
        end
        prev_ss_m   = bus2.ss;
        prev_sclk_m = bus2.sclk;
    end

    typedef struct {
        logic [7:0] tx;
        logic       loop;
        logic [7:0] slave_word;
        int         re_at;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One transfer on the CLK_DIV=2 instance with all timing checks.
    task automatic run_xfer(input vec_t v, input string tag);
        int   ss_low, rises, done_cnt, first_rise, unstable, post_low;
        logic busy0, prev_sclk, prev_mosi, seen_done;
        ss_low = 0; rises = 0; done_cnt = 0; first_rise = -1;
        unstable = 0; post_low = 0; busy0 = 1'b0; seen_done = 1'b0;
        use_loop   = v.loop;
        slave_word = v.slave_word;
        @(negedge clk);
        bus2.data_tx = v.tx;
        bus2.start   = 1'b1;
        prev_sclk = bus2.sclk;
        prev_mosi = bus2.mosi;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus2.start   = 1'b0;
                bus2.data_tx = ~v.tx;
                busy0        = bus2.busy;
            end
            if (c == v.re_at) begin
                bus2.start   = 1'b1;
                bus2.data_tx = 8'hFF;
            end
            if (c == v.re_at + 1) bus2.start = 1'b0;
            if (!bus2.ss) ss_low++;
            if (bus2.sclk && !prev_sclk) begin
                rises++;
                if (first_rise < 0) first_rise = c;
                if (bus2.mosi !== prev_mosi) unstable++;
            end
            if (bus2.done) begin
                done_cnt++;
                seen_done = 1'b1;
            end else if (seen_done) begin
                break;
            end
            prev_sclk = bus2.sclk;
            prev_mosi = bus2.mosi;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus2.ss) post_low++;
            if (bus2.done) done_cnt++;
        end
        check({tag, "_busy_after_start"}, busy0, 1);
        check({tag, "_ss_low_cycles"}, ss_low, 34);
        check({tag, "_sclk_rises"}, rises, 8);
        check({tag, "_first_rise_delay"}, first_rise, 2);
        check({tag, "_mosi_unstable"}, unstable, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_data_rx"}, bus2.data_rx, v.exp_rx);
        check({tag, "_idle_after"}, {bus2.busy, post_low[7:0]}, 0);
        if (!v.loop) check({tag, "_slave_rx"}, s_rx, v.tx);
    endtask

    vec_t vecs[6];

    initial begin
        int   bad;
        int   rises, dseen;
        logic prev;

        vecs[0] = '{8'hA5, 1'b1, 8'h00, -1, 8'hA5};
        vecs[1] = '{8'hC3, 1'b0, 8'h3C, -1, 8'h3C};
        vecs[2] = '{8'hF0, 1'b1, 8'h00, -1, 8'hF0};
        vecs[3] = '{8'h00, 1'b0, 8'hFF, -1, 8'hFF};
        vecs[4] = '{8'h81, 1'b0, 8'h7E, -1, 8'h7E};
        vecs[5] = '{8'h66, 1'b1, 8'h00,  6, 8'h66};

        bus2.start = 1'b0; bus2.data_tx = 8'h00;
        bus1.start = 1'b0; bus1.data_tx = 8'h00;

        // Reset values.
        @(negedge clk);
        check("reset_pins", {bus2.sclk, bus2.ss, bus2.mosi, bus2.busy, bus2.done}, 5'b01000);
        check("reset_data_rx", bus2.data_rx, 0);
        check("reset_pins_div1", {bus1.sclk, bus1.ss, bus1.mosi, bus1.busy, bus1.done}, 5'b01000);
        rst2 = 1'b0;
        rst1 = 1'b0;

        // Quiet bus with no start.
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if ({bus2.sclk, bus2.ss, bus2.mosi, bus2.busy} !== 4'b0100) bad++;
        end
        check("idle_100_cycles", bad, 0);

        for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Reset at the 4th rising sclk edge aborts the transfer.
        use_loop = 1'b1;
        @(negedge clk);
        bus2.data_tx = 8'h96;
        bus2.start   = 1'b1;
        rises = 0; dseen = 0; prev = bus2.sclk;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) bus2.start = 1'b0;
            if (bus2.sclk && !prev) rises++;
            prev = bus2.sclk;
            if (bus2.done) dseen++;
            if (rises == 4) break;
        end
        check("abort_reached_rise4", rises, 4);
        rst2 = 1'b1;
        @(negedge clk);
        check("abort_pins", {bus2.sclk, bus2.ss, bus2.busy, bus2.done}, 4'b0100);
        check("abort_data_rx", bus2.data_rx, 0);
        rst2 = 1'b0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus2.done || !bus2.ss) bad++;
        end
        check("abort_no_done", bad + dseen, 0);
        run_xfer('{8'h5A, 1'b1, 8'h00, -1, 8'h5A}, "after_abort");

        // CLK_DIV=1 with start held high: back-to-back transfers.
        begin
            int   low_run, high_run, done_run, lows_done, rises1;
            logic prev_ss, prev_sclk, seen_low;
            low_run = 0; high_run = 0; done_run = 0; lows_done = 0; rises1 = 0;
            prev_ss = 1'b1; prev_sclk = 1'b0; seen_low = 1'b0;
            @(negedge clk);
            bus1.data_tx = 8'hA5;
            bus1.start   = 1'b1;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (!bus1.ss && prev_ss) begin
                    if (seen_low) check("div1_ss_high_gap", high_run, 1);
                    seen_low = 1'b1;
                    low_run  = 0;
                    rises1   = 0;
                end
                if (bus1.ss && !prev_ss) begin
                    check("div1_ss_low_len", low_run, 17);
                    check("div1_rises", rises1, 8);
                    check("div1_data_rx", bus1.data_rx, 8'hA5);
                    lows_done++;
                    high_run = 0;
                end
                if (!bus1.ss) begin
                    low_run++;
                    if (bus1.sclk && !prev_sclk) rises1++;
                end else begin
                    high_run++;
                end
                if (bus1.done) begin
                    done_run++;
                end else if (done_run != 0) begin
                    check("div1_done_width", done_run, 1);
                    done_run = 0;
                end
                prev_ss   = bus1.ss;
                prev_sclk = bus1.sclk;
                if (lows_done == 3) break;
            end
            check("div1_transfers", lows_done, 3);
            bus1.start = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_spi_master

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master: the initiating end of the link our SPI slave answers.
- Generates sclk and ss_n from the system clock, shifts data_tx out on mosi MSB-first, and shifts miso into data_rx.
- Single-transfer engine driven by a start pulse, with busy/done status for the local controller.
- Sits between the local controller and the off-block SPI pins.

Parameters:
- DATA_W, 8: bits per transfer.
- CLK_DIV, 2: system-clock cycles per sclk half-period; minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- data_tx  input  DATA_W  word to send; latched on accepted start.
- miso  input  1  serial data from slave.
- sclk  output  1  SPI clock; idle low.
- ss  output  1  slave select, active low; idle high.
- mosi  output  1  serial data to slave.
- data_rx  output  DATA_W  last received word; valid from done onward.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset values (registered outputs, applied on the first clk edge with rst=1):
  - sclk=0, ss=1, mosi=0, busy=0, done=0, data_rx=0.
  - State=IDLE; internal counters and shift registers cleared.
- Reset mid-transfer aborts immediately: ss=1 and sclk=0 on the next edge, data_rx=0, no done pulse.
- State machine IDLE -> XFER -> TRAIL -> IDLE.
- IDLE, start=1:
  - Latch data_tx into tx_shift; ss<=0; busy<=1; mosi<=data_tx[DATA_W-1].
  - bit_cnt<=DATA_W, div_cnt<=0; go to XFER.
  - start=0 leaves all outputs unchanged.
- Divider:
  - div_cnt counts 0..CLK_DIV-1; tick when div_cnt==CLK_DIV-1, then div_cnt wraps to 0.
  - div_cnt is reset to 0 on every state entry.
- XFER, on tick with sclk=0 (rising edge):
  - sclk<=1; rx_shift<={rx_shift[DATA_W-2:0], miso}; bit_cnt<=bit_cnt-1.
- XFER, on tick with sclk=1 (falling edge):
  - sclk<=0.
  - If bit_cnt==0, go to TRAIL; mosi holds its value.
  - Else shift tx_shift left and drive mosi with the next MSB.
- TRAIL, on tick: ss<=1, busy<=0, done<=1, data_rx<=rx_shift; go to IDLE.
- done deasserts the following cycle.
- Timing:
  - ss is low for exactly (2*DATA_W+1)*CLK_DIV cycles.
  - Exactly DATA_W rising sclk edges per transfer.
  - First rising edge occurs CLK_DIV cycles after ss falls.
  - mosi is stable for a full half-period before each rising edge.
- start while busy (XFER/TRAIL) is ignored; it is not queued.
- start in the same cycle done is high (state IDLE) is accepted. Back-to-back transfers therefore have ss high for at least 1 cycle.
- data_tx changes after acceptance have no effect on the transfer in progress.
- data_rx holds its value between transfers.
- CLK_DIV=1: sclk toggles every cycle and all rules above still hold.
- Widths:
  - bit_cnt is $clog2(DATA_W+1) bits.
  - div_cnt is max(1,$clog2(CLK_DIV)) bits.

Decomposition:
- Package spi_pkg:
  - State enum (IDLE, XFER, TRAIL).
  - Default DATA_W.
  - Mode-0 constants CPOL=0, CPHA=0, for shared use with the slave side.
- Sub-module spi_clk_div: parameterised CLK_DIV counter with clear input and one-cycle tick output. It is the natural split; the FSM and shifters stay in spi_master.

Test Plan:
- Loopback: tie miso to mosi, data_tx=8'hA5, CLK_DIV=2, pulse start -> 8 rising sclk edges; ss low for 34 cycles; done 1 cycle; data_rx=8'hA5.
- Behavioural mode-0 slave model returning 8'h3C, data_tx=8'hC3 -> model captures 8'hC3; data_rx=8'h3C; mosi bit order 1,1,0,0,0,0,1,1.
- start pulsed again mid-XFER with data_tx=8'hFF -> ignored; only one done pulse; original word transmitted.
- rst asserted at the 4th rising sclk edge -> next cycle ss=1, sclk=0, busy=0, data_rx=0, no done. A new start afterwards completes normally with 8'h5A looped back.
- CLK_DIV=1, start held high continuously -> consecutive transfers; ss high exactly 1 cycle between them; each done pulse 1 cycle wide; ss low 17 cycles each.
- Idle check after reset with no start for 100 cycles -> sclk=0, ss=1, mosi=0, busy=0 throughout.
